// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: KGP-RISC instruction fetch stage. Produces the PC, fetches words
// over a req/ready memory port into a 2-entry queue, and hands the head word to
// decode. Redirects flush the queue. A redirect that lands while a memory
// request is still waiting parks in DROP until that stale response arrives.
module fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [3:0]      opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);

    typedef enum logic {FETCH, DROP} fetchState_e;

    fetchState_e     state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt;
    logic            pend;
    logic [31:0]     qData [2];
    logic [PC_W-1:0] qPc   [2];
    logic            head;
    logic [1:0]      count;

    logic            memFire;
    logic            memWait;
    logic            pushFire;
    logic            popFire;
    logic            wrIdx;
    logic [PC_W-1:0] redirectAligned;

    // A request stays up while draining a wrong-path word, while one is
    // outstanding, or while the queue still has room; reset kills it outright.
    assign imem_req  = ~rst & ((state == DROP) | pend | (count < 2'd2));
    assign imem_addr = pc;

    assign memFire         = imem_req & imem_ready;
    assign memWait         = imem_req & ~imem_ready;
    assign popFire         = instr_valid & instr_ready;
    assign pushFire        = memFire & (state == FETCH) & ~redirect;
    assign wrIdx           = head ^ count[0];
    assign redirectAligned = {redirect_pc[PC_W-1:2], 2'b00};

    // The decode-facing outputs come straight from the queue registers.
    assign instr       = qData[head];
    assign instr_pc    = qPc[head];
    assign opcode      = instr[31:28];
    assign instr_valid = (count != 2'd0);

    // Single state process: reset beats redirect, which beats normal fetch/dequeue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            tgt      <= '0;
            pend     <= 1'b0;
            head     <= 1'b0;
            count    <= 2'd0;
            qData[0] <= '0;
            qData[1] <= '0;
            qPc[0]   <= '0;
            qPc[1]   <= '0;
        end else begin
            pend <= memWait;
            if (redirect) begin
                count <= 2'd0;
                head  <= 1'b0;
                if (state == DROP) begin
                    tgt <= redirectAligned;
                    if (imem_ready) begin
                        pc    <= redirectAligned;
                        state <= FETCH;
                    end
                end else if (memWait) begin
                    tgt   <= redirectAligned;
                    state <= DROP;
                end else begin
                    pc <= redirectAligned;
                end
            end else if (state == DROP) begin
                if (imem_ready) begin
                    pc    <= tgt;
                    state <= FETCH;
                end
            end else begin
                if (pushFire) begin
                    qData[wrIdx] <= imem_rdata;
                    qPc[wrIdx]   <= pc;
                    pc           <= pc + PC_W'(4);
                end
                if (popFire) begin
                    head <= ~head;
                end
                count <= count + {1'b0, pushFire} - {1'b0, popFire};
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed scenarios followed by a randomized phase. The reference
// model treats the instruction stream abstractly: after reset or a redirect the
// consumer must see consecutive words starting at the (aligned) target, each
// carrying the word stored at its address. A monitor checks every handshake
// against that queue.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } expItem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemReady = 1'b0;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [3:0]  opcode;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    expItem_t    expQ[$];
    logic [31:0] nextPc = '0;

    logic        prevRedirect = 1'b0;
    logic        prevWait = 1'b0;
    logic        prevRst = 1'b1;
    logic [31:0] prevAddr = '0;

    // Memory contents: word 0 carries opcode 0xA, others are an address hash.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'hA000_0000;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imemRdata = memWord(imemAddr);

    fetch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_rdata  (imemRdata),
        .imem_ready  (imemReady),
        .instr       (instr),
        .instr_pc    (instrPc),
        .opcode      (opcode),
        .instr_valid (instrValid),
        .instr_ready (instrReady),
        .redirect    (redirect),
        .redirect_pc (redirectPc)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Keep the expected stream a few words ahead of the consumer.
    task automatic refill();
        while (expQ.size() < 4) begin
            expQ.push_back('{pc: nextPc, data: memWord(nextPc)});
            nextPc = nextPc + 32'd4;
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the
    // falling edge so the caller can sample settled outputs.
    task automatic applyStimulus(input logic rstV, input logic readyV, input logic irdyV,
                                 input logic redirV, input logic [31:0] rpcV);
        @(posedge clk);
        #1;
        rst        = rstV;
        imemReady  = readyV;
        instrReady = irdyV;
        redirect   = redirV;
        redirectPc = rpcV;
        refill();
        @(negedge clk);
    endtask

    task automatic checkResetState();
        checkOutput("resetReq",    {31'b0, imemReq},    32'h0);
        checkOutput("resetAddr",   imemAddr,            32'h0);
        checkOutput("resetValid",  {31'b0, instrValid}, 32'h0);
        checkOutput("resetInstr",  instr,               32'h0);
        checkOutput("resetInstrPc", instrPc,            32'h0);
        checkOutput("resetOpcode", {28'b0, opcode},     32'h0);
    endtask

    // Monitor: compare each consumer handshake against the scoreboard, check the
    // memory hold rule and the post-redirect flush, then apply redirect/reset to
    // the model so it describes the following cycles.
    always @(negedge clk) begin
        if (!rst && !prevRst) begin
            if (prevRedirect)
                checkOutput("flushAfterRedirect", {31'b0, instrValid}, 32'h0);
            if (prevWait) begin
                checkOutput("reqHeld",  {31'b0, imemReq}, 32'h1);
                checkOutput("addrHeld", imemAddr,         prevAddr);
            end
        end
        if (!rst && instrValid && instrReady) begin
            pops++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWord", instrPc, 32'hFFFF_FFFF);
            end else begin
                expItem_t e;
                e = expQ.pop_front();
                checkOutput("instrPc", instrPc,          e.pc);
                checkOutput("instr",   instr,            e.data);
                checkOutput("opcode",  {28'b0, opcode},  {28'b0, e.data[31:28]});
            end
        end
        if (rst) begin
            expQ.delete();
            nextPc = 32'h0;
        end else if (redirect) begin
            expQ.delete();
            nextPc = redirectPc & ~32'h3;
        end
        prevRedirect = redirect;
        prevWait     = imemReq & ~imemReady;
        prevRst      = rst;
        prevAddr     = imemAddr;
    end

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        $display("[TB] starting fetch_unit bench");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkResetState();

        // Streaming with memory and consumer always ready.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("streamAddr", imemAddr, 32'(4 * k));
            if (k >= 1) begin
                checkOutput("streamValid", {31'b0, instrValid}, 32'h1);
                checkOutput("streamPcLag", instrPc, 32'(4 * (k - 1)));
            end
            if (k == 1)
                checkOutput("opcodeA", {28'b0, opcode}, 32'hA);
        end

        // Backpressure: queue fills to two and the request drops.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            if (k >= 1) begin
                checkOutput("bpReqLow", {31'b0, imemReq},    32'h0);
                checkOutput("bpValid",  {31'b0, instrValid}, 32'h1);
            end
        end
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect on an accepted fetch; low address bits ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h103);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redirAddr", imemAddr, 32'h100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redirFirstPc", instrPc, 32'h100);

        // Redirect while the memory is stalling.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("dropTarget", imemAddr, 32'h200);

        // Two redirects before the stalled response arrives.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h400);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("doubleRedir", imemAddr, 32'h400);

        // PC wrap, then reset while a request is outstanding.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrapAddr0", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrapAddr1", imemAddr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("reqLowInRst", {31'b0, imemReq}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkResetState();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'b0,
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 99) < 8),
                          32'($urandom_range(0, 4095)));
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("progress", {31'b0, (pops > 100)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the KGP-RISC core. Generates the program counter, fetches 32-bit instruction words over a req/ready instruction-memory port, and buffers them in a 2-entry queue. Presents the head instruction, its PC and its 4-bit opcode to the decode/control stage through a valid/ready handshake. Accepts branch/jump redirects from the execute stage and squashes any wrong-path words, including one already in flight.

## Interface
Parameters:
- PC_W, 32, program-counter and instruction-address width.
- RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  PC_W  fetch address; equals internal pc.
- imem_rdata  input  32  instruction word; valid in any cycle where imem_req and imem_ready are both high.
- imem_ready  input  1  memory accepts the request and returns data in the same cycle.
- instr  output  32  head-of-queue instruction.
- instr_pc  output  PC_W  address of instr.
- opcode  output  4  instr[31:28], routed to the control decoder.
- instr_valid  output  1  queue not empty.
- instr_ready  input  1  consumer takes the head this cycle when instr_valid is also high.
- redirect  input  1  branch taken or jump; flush and restart fetch.
- redirect_pc  input  PC_W  new fetch address; bits [1:0] are ignored and treated as 0.

## Operation
- State: pc, 2-entry queue (data plus PC per entry, with head pointer and count 0..2), pend flag, FSM {FETCH, DROP}, and tgt register.
- imem_req = (state==DROP) | pend | (count<2). It is combinational from registered state only, never from imem_ready.
- Memory rule: once imem_req is high, it stays high with imem_addr unchanged until imem_ready is sampled high.
- pend is set when req & ~ready. It clears on ready.
- FETCH, req & ready: push {imem_rdata, pc} and set pc <= pc+4. The add wraps modulo 2^PC_W.
- Space guarantee: a request is started only with count<2. Count cannot increase while the request is outstanding, so a push never overflows.
- Dequeue: on instr_valid & instr_ready, advance head and decrement count.
- Simultaneous push and pop: count is unchanged and both take effect. At count==2, a pop in the same cycle as a push is legal.
- Redirect handling. Priority is rst > redirect > normal operation.
  - The queue is flushed next cycle (count <= 0). A pop handshake in the redirect cycle is counted as completed.
  - If req & ready, or no request is active: discard this cycle's imem_rdata, set pc <= {redirect_pc[PC_W-1:2],2'b00}, and stay in FETCH.
  - If req & ~ready: set tgt <= aligned redirect_pc and go to DROP. pc is held.
- DROP state:
  - imem_req stays high at the old pc.
  - On ready: discard the data, set pc <= tgt, go to FETCH, and clear pend.
  - Any push is suppressed.
  - A new redirect while in DROP overwrites tgt. If it coincides with ready, the new redirect_pc wins.
- Reset values: pc=RESET_PC, count=0, instr_valid=0, instr=0, instr_pc=0, pend=0, state=FETCH, tgt=0.
  - imem_req is forced to 0 while rst is high.
  - Reset mid-request abandons the transaction. The memory must tolerate a dropped request on reset.

## Timing
- First request is in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Fetch-to-valid latency is 1 cycle: a word accepted in cycle N appears on instr with instr_valid=1 in cycle N+1.
- Throughput is 1 instruction/cycle with imem_ready and instr_ready held high.
- With instr_ready low, at most 2 words are buffered. imem_req drops in the cycle after count reaches 2.
- Redirect at cycle N with ready:
  - The new address is on imem_addr at N+1.
  - instr_valid=0 at N+1.
  - The first target instruction is valid at N+2.
- Redirect into DROP: the target is fetched in the cycle after the stalled response arrives.
- opcode, instr and instr_pc are registered-queue outputs; there is no combinational path from imem_rdata.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC=0, memory always ready, instr_ready=1.
  - Response: imem_addr sequence 0,4,8,…; instr_pc lags by one cycle; opcode=instr[31:28] for word 0xA000_0000 gives 0xA.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles.
  - Response: exactly 2 words buffered; imem_req=0 once count=2; on release, words come out in order with no loss or duplication.
- Redirect on accepted fetch:
  - Stimulus: redirect=1, redirect_pc=0x103 while req & ready.
  - Response: next imem_addr=0x100; the queue is empty; the discarded word never appears on instr.
- Redirect during wait:
  - Stimulus: memory holds ready low for 3 cycles; redirect to 0x200 in the second wait cycle.
  - Response: req held at the old address; the stale response is dropped; the next request is 0x200.
- Double redirect in DROP:
  - Stimulus: redirect to 0x300 then 0x400 before ready.
  - Response: the first fetch after DROP is 0x400.
- PC wrap and reset mid-request:
  - Stimulus: redirect to 0xFFFF_FFFC; then assert rst during an outstanding request.
  - Response: the address sequence is 0xFFFF_FFFC then 0x0000_0000. In the cycle after reset, all outputs are at reset values and imem_req=0 while rst is high.
